// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
// issue_pkg : shared types, constants and helpers for the issue-stage buffer
// Revision  : 1.0
// ============================================================================
package issue_pkg;

  localparam int ISSUE_DATA_W = 128;
  localparam int RD_W         = 5;
  localparam int NREGS        = 32;
  localparam int KILL_W       = 3;

  localparam logic [ISSUE_DATA_W-1:0] BUBBLE = '0;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            we;
  } dst_t;

  // Register 0 is hardwired, so it is never reported busy.
  function automatic logic [NREGS-1:0] onehot_rd(input logic [RD_W-1:0] rd,
                                                 input logic            we);
    logic [NREGS-1:0] mask;
    mask = '0;
    if (we && (rd != '0)) mask[rd] = 1'b1;
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_buf_fifo.sv
`default_nettype none
// ============================================================================
// issue_buf_fifo : in-order storage array with pointers, count and flush
// Revision       : 1.0
// ============================================================================
module issue_buf_fifo
  import issue_pkg::*;
#(
  parameter int DATA_W = ISSUE_DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  dst_t                       wr_dst_i,
  output logic                       head_valid_o,
  output logic [DATA_W-1:0]          head_data_o,
  output dst_t                       head_dst_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [DEPTH-1:0]           ent_valid_o,
  output dst_t [DEPTH-1:0]           ent_dst_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  dst_t [DEPTH-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] data_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    vld_d    = vld_q;
    dst_d    = dst_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      vld_d    = '0;
    end else begin
      if (push_i) begin
        vld_d[wr_ptr_q] = 1'b1;
        dst_d[wr_ptr_q] = wr_dst_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      dst_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      dst_q    <= dst_d;
    end
  end

  // Payload needs no reset: it is only observed through a valid flag.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) data_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_valid_o = vld_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign head_dst_o   = dst_q[rd_ptr_q];
  assign count_o      = count_q;
  assign ent_valid_o  = vld_q;
  assign ent_dst_o    = dst_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !flush_i && !pop_i && (count_q == CNT_W'(DEPTH))));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && !flush_i && (count_q == '0)));

endmodule
`default_nettype wire

// File: rtl/issue_buffer.sv
`default_nettype none
// ============================================================================
// issue_buffer : decode-to-execute FIFO with handshake, kill shadow and busy mask
// Revision     : 1.0
// ============================================================================
module issue_buffer
  import issue_pkg::*;
#(
  parameter int DATA_W      = ISSUE_DATA_W,
  parameter int DEPTH       = 2,
  parameter int KILL_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic [RD_W-1:0]            in_rd_i,
  input  logic                       in_we_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [RD_W-1:0]            out_rd_o,
  output logic                       out_we_o,
  input  logic                       discard_i,
  input  logic                       kill_i,
  input  logic                       hold_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       kill_active_o,
  output logic [NREGS-1:0]           rd_busy_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [KILL_W-1:0] kill_cnt_q, kill_cnt_d;
  logic              w_kill_active, w_push, w_pop, w_flush;
  logic              w_head_valid;
  logic [DATA_W-1:0] w_head_data;
  dst_t              w_head_dst;
  logic [CNT_W-1:0]  w_count;
  logic [DEPTH-1:0]  w_ent_valid;
  dst_t [DEPTH-1:0]  w_ent_dst;

  assign w_kill_active = (kill_cnt_q != '0);
  // Beats arriving during the shadow are acknowledged so decode drains, then dropped.
  assign in_ready_o    = (w_count < CNT_W'(DEPTH)) | w_kill_active;
  assign w_flush       = discard_i | kill_i;
  assign w_push        = in_valid_i & in_ready_o & ~w_kill_active & ~w_flush;
  assign w_pop         = w_head_valid & out_ready_i & ~hold_i & ~w_flush;

  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (discard_i)               kill_cnt_d = '0;
    else if (kill_i)             kill_cnt_d = KILL_W'(KILL_CYCLES);
    else if (kill_cnt_q != '0)   kill_cnt_d = kill_cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) kill_cnt_q <= '0;
    else         kill_cnt_q <= kill_cnt_d;
  end

  issue_buf_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (w_flush),
    .push_i       (w_push),
    .pop_i        (w_pop),
    .wr_data_i    (in_data_i),
    .wr_dst_i     ('{rd: in_rd_i, we: in_we_i}),
    .head_valid_o (w_head_valid),
    .head_data_o  (w_head_data),
    .head_dst_o   (w_head_dst),
    .count_o      (w_count),
    .ent_valid_o  (w_ent_valid),
    .ent_dst_o    (w_ent_dst)
  );

  // Empty head presents an all-zero NOP to execute.
  assign out_valid_o   = w_head_valid;
  assign out_data_o    = w_head_valid ? w_head_data   : DATA_W'(BUBBLE);
  assign out_rd_o      = w_head_valid ? w_head_dst.rd : '0;
  assign out_we_o      = w_head_valid & w_head_dst.we;
  assign count_o       = w_count;
  assign kill_active_o = w_kill_active;

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i]) rd_busy_o = rd_busy_o | onehot_rd(w_ent_dst[i].rd, w_ent_dst[i].we);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_buffer.sv
`default_nettype none
// ============================================================================
// tb_issue_buffer : directed self-checking bench for issue_buffer
// Revision        : 1.0
// ============================================================================
module tb_issue_buffer;
  import issue_pkg::*;

  localparam int DW    = 128;
  localparam int DEPTH = 2;
  localparam int KC    = 2;
  localparam int CW    = $clog2(DEPTH+1);

  localparam logic [DW-1:0] PA = {4{32'hA0A0_0001}};
  localparam logic [DW-1:0] PB = {4{32'hB0B0_0002}};
  localparam logic [DW-1:0] PC = {4{32'hC0C0_0003}};
  localparam logic [DW-1:0] PD = {4{32'hD0D0_0004}};
  localparam logic [DW-1:0] PE = {4{32'hE0E0_0005}};
  localparam logic [DW-1:0] PX = {4{32'h5A5A_0006}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_we;
  logic [DW-1:0] in_data;
  logic [4:0]    in_rd;
  logic          out_valid, out_ready, out_we;
  logic [DW-1:0] out_data;
  logic [4:0]    out_rd;
  logic          discard, kill, hold, kill_active;
  logic [CW-1:0] count;
  logic [31:0]   rd_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .KILL_CYCLES(KC)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .in_rd_i(in_rd), .in_we_i(in_we),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_rd_o(out_rd), .out_we_o(out_we),
    .discard_i(discard), .kill_i(kill), .hold_i(hold),
    .count_o(count), .kill_active_o(kill_active), .rd_busy_o(rd_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; out_ready = 0; discard = 0; kill = 0; hold = 0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [4:0] rd, input logic we);
    in_valid = 1; in_data = d; in_rd = rd; in_we = we;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); beat(PX, 5'd3, 1'b1); in_valid = 0;
    #12;
    checks++;
    if ({out_valid, in_ready, count, kill_active, out_we, out_rd} !== {1'b0, 1'b1, CW'(0), 1'b0, 1'b0, 5'd0}) begin
      errors++; $display("FAIL reset_ctrl: got v=%0b rdy=%0b cnt=%0d ka=%0b we=%0b rd=%0d want 0 1 0 0 0 0",
                         out_valid, in_ready, count, kill_active, out_we, out_rd);
    end
    checks++;
    if (out_data !== '0 || rd_busy !== 32'h0) begin
      errors++; $display("FAIL reset_data: got data=%h busy=%h want 0 0", out_data, rd_busy);
    end
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_fill();
    idle(); beat(PA, 5'd5, 1'b1); step();
    checks++;
    if (count !== 1 || out_valid !== 1'b1 || out_data !== PA || out_rd !== 5'd5 || out_we !== 1'b1) begin
      errors++; $display("FAIL fill_first: got cnt=%0d v=%0b rd=%0d we=%0b want 1 1 5 1", count, out_valid, out_rd, out_we);
    end
    beat(PB, 5'd7, 1'b1); step();
    checks++;
    if (count !== 2 || in_ready !== 1'b0 || rd_busy !== 32'h0000_00A0 || out_data !== PA) begin
      errors++; $display("FAIL fill_full: got cnt=%0d rdy=%0b busy=%h want 2 0 000000a0", count, in_ready, rd_busy);
    end
    beat(PC, 5'd9, 1'b1); step();
    checks++;
    if (count !== 2 || rd_busy !== 32'h0000_00A0 || out_data !== PA) begin
      errors++; $display("FAIL fill_overflow: got cnt=%0d busy=%h want 2 000000a0", count, rd_busy);
    end
    in_valid = 0; out_ready = 1; step();
    checks++;
    if (count !== 1 || out_data !== PB || out_rd !== 5'd7 || rd_busy !== 32'h0000_0080) begin
      errors++; $display("FAIL drain_one: got cnt=%0d rd=%0d busy=%h want 1 7 00000080", count, out_rd, rd_busy);
    end
    step();
    checks++;
    if (count !== 0 || out_valid !== 1'b0 || out_data !== '0 || out_rd !== 5'd0 || out_we !== 1'b0 || rd_busy !== 32'h0) begin
      errors++; $display("FAIL bubble: got cnt=%0d v=%0b rd=%0d we=%0b busy=%h want all 0", count, out_valid, out_rd, out_we, rd_busy);
    end
    out_ready = 0;
  endtask

  task automatic test_stream();
    logic [DW-1:0] d;
    logic [31:0]   busy;
    idle(); out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      d = {96'h0, 32'h1000_0000 + 32'(k)};
      beat(d, 5'(k + 1), 1'(k % 2));
      step();
      busy = (k % 2 == 1) ? (32'h1 << (k + 1)) : 32'h0;
      checks++;
      if (out_data !== d || out_rd !== 5'(k + 1) || count !== 1 || out_valid !== 1'b1 || rd_busy !== busy) begin
        errors++; $display("FAIL stream_%0d: got data=%h rd=%0d cnt=%0d busy=%h want data=%h rd=%0d cnt=1 busy=%h",
                           k, out_data[31:0], out_rd, count, rd_busy, d[31:0], k + 1, busy);
      end
    end
    in_valid = 0; step();
    checks++;
    if (count !== 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_end: got cnt=%0d v=%0b want 0 0", count, out_valid);
    end
    out_ready = 0;
  endtask

  task automatic test_kill();
    idle();
    beat(PA, 5'd3, 1'b1); step();
    beat(PB, 5'd4, 1'b1); step();
    kill = 1; beat(PX, 5'd6, 1'b1); step(); kill = 0;
    checks++;
    if (count !== 0 || kill_active !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 || rd_busy !== 32'h0) begin
      errors++; $display("FAIL kill_flush: got cnt=%0d ka=%0b v=%0b rdy=%0b busy=%h want 0 1 0 1 0",
                         count, kill_active, out_valid, in_ready, rd_busy);
    end
    beat(PC, 5'd10, 1'b1); step();
    checks++;
    if (count !== 0 || kill_active !== 1'b1) begin
      errors++; $display("FAIL kill_drop1: got cnt=%0d ka=%0b want 0 1", count, kill_active);
    end
    beat(PD, 5'd11, 1'b1); step();
    checks++;
    if (count !== 0 || kill_active !== 1'b0) begin
      errors++; $display("FAIL kill_drop2: got cnt=%0d ka=%0b want 0 0", count, kill_active);
    end
    beat(PE, 5'd8, 1'b1); step();
    checks++;
    if (count !== 1 || out_data !== PE || rd_busy !== 32'h0000_0100) begin
      errors++; $display("FAIL kill_third: got cnt=%0d busy=%h want 1 00000100", count, rd_busy);
    end
    in_valid = 0; out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_kill_restart();
    idle();
    kill = 1; step(); step(); kill = 0;
    step();
    checks++;
    if (kill_active !== 1'b1) begin
      errors++; $display("FAIL kill_restart: got ka=%0b want 1", kill_active);
    end
    step();
    checks++;
    if (kill_active !== 1'b0) begin
      errors++; $display("FAIL kill_restart_end: got ka=%0b want 0", kill_active);
    end
  endtask

  task automatic test_discard();
    idle();
    beat(PA, 5'd2, 1'b1); step(); in_valid = 0;
    kill = 1; step(); kill = 0;
    discard = 1; step(); discard = 0;
    checks++;
    if (kill_active !== 1'b0 || count !== 0) begin
      errors++; $display("FAIL discard_shadow: got ka=%0b cnt=%0d want 0 0", kill_active, count);
    end
    beat(PB, 5'd11, 1'b1); step(); in_valid = 0;
    checks++;
    if (count !== 1 || out_data !== PB || rd_busy !== 32'h0000_0800) begin
      errors++; $display("FAIL discard_accept: got cnt=%0d busy=%h want 1 00000800", count, rd_busy);
    end
    discard = 1; kill = 1; step(); discard = 0; kill = 0;
    checks++;
    if (count !== 0 || kill_active !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL discard_over_kill: got cnt=%0d ka=%0b v=%0b want 0 0 0", count, kill_active, out_valid);
    end
  endtask

  task automatic test_hold();
    idle();
    beat(PC, 5'd12, 1'b1); step();
    hold = 1; out_ready = 1;
    beat(PD, 5'd13, 1'b1); step();
    checks++;
    if (out_data !== PC || count !== 2) begin
      errors++; $display("FAIL hold_1: got cnt=%0d rd=%0d want 2 12", count, out_rd);
    end
    beat(PE, 5'd14, 1'b1);
    for (int i = 2; i <= 3; i++) begin
      step();
      checks++;
      if (out_data !== PC || count !== 2 || in_ready !== 1'b0 || rd_busy !== 32'h0000_3000) begin
        errors++; $display("FAIL hold_%0d: got cnt=%0d rdy=%0b rd=%0d busy=%h want 2 0 12 00003000",
                           i, count, in_ready, out_rd, rd_busy);
      end
    end
    hold = 0; step();
    checks++;
    if (out_data !== PD || count !== 1) begin
      errors++; $display("FAIL hold_resume1: got cnt=%0d rd=%0d want 1 13", count, out_rd);
    end
    step();
    checks++;
    if (out_data !== PE || count !== 1) begin
      errors++; $display("FAIL hold_resume2: got cnt=%0d rd=%0d want 1 14", count, out_rd);
    end
    in_valid = 0; step(); out_ready = 0;
  endtask

  task automatic test_reset_mid();
    idle();
    beat(PA, 5'd5, 1'b1); step();
    beat(PB, 5'd7, 1'b1); step(); in_valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || count !== 0 || rd_busy !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got v=%0b cnt=%0d busy=%h rdy=%0b want 0 0 0 1", out_valid, count, rd_busy, in_ready);
    end
    @(negedge clk); rst_n = 1;
    step();
    checks++;
    if (count !== 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got cnt=%0d v=%0b want 0 0", count, out_valid);
    end
  endtask

  initial begin
    in_data = '0; in_rd = '0; in_we = 0;
    test_reset();
    test_fill();
    test_stream();
    test_kill();
    test_kill_restart();
    test_discard();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
